// File: rtl/ins_prefetch_if.sv
// Pipelined Wishbone bus bundle shared by the CPU-side and MMU-side ports
// of the instruction prefetch buffer.
interface if_wb;
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        stall;

    modport master (
        output adr, cyc, stb, we, sel, dat_m,
        input  dat_s, ack, stall
    );

    modport slave (
        input  adr, cyc, stb, we, sel, dat_m,
        output dat_s, ack, stall
    );
endinterface

// File: rtl/ins_prefetch.sv
// Instruction prefetch buffer: streams sequential words from the MMU into a
// small FIFO and serves matching CPU reads from it; branches flush the stream.
module ins_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  cpubus,
    if_wb.master membus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Repeated branches can stack several drains, so discard gets headroom.
    localparam int DW = CW + 4;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [DW-1:0] r_discard;
    logic [31:0]   r_head_adr;
    logic [31:0]   r_next_adr;
    logic          r_valid;
    logic          r_ack;
    logic [31:0]   r_dat_s;

    logic          w_rd;
    logic          w_wr;
    logic          w_hit;
    logic          w_flush;
    logic          w_issue;
    logic          w_fire;
    logic          w_push;
    logic          w_drop;
    logic [CW:0]   w_level;
    logic          w_unused;

    assign w_rd    = cpubus.cyc & cpubus.stb & ~cpubus.we;
    assign w_wr    = cpubus.cyc & cpubus.stb & cpubus.we;
    assign w_hit   = w_rd & r_valid & (r_count != '0) & (cpubus.adr == r_head_adr);
    assign w_flush = w_rd & (~r_valid | (cpubus.adr != r_head_adr));
    assign w_level = {1'b0, r_count} + {1'b0, r_outst};
    assign w_issue = r_valid & (w_level < DEPTH_L) & ~w_flush;
    assign w_fire  = w_issue & ~membus.stall;
    assign w_drop  = membus.ack & (r_discard != '0);
    assign w_push  = membus.ack & (r_discard == '0);

    assign cpubus.stall = w_rd & ~w_hit;
    assign cpubus.ack   = r_ack;
    assign cpubus.dat_s = r_dat_s;

    assign membus.stb   = w_issue;
    assign membus.cyc   = w_issue | (r_outst != '0) | (r_discard != '0);
    assign membus.adr   = r_next_adr;
    assign membus.we    = 1'b0;
    assign membus.sel   = 4'hF;
    assign membus.dat_m = '0;

    assign w_unused = ^{cpubus.sel, cpubus.dat_m};

    // FIFO storage; a flush drops the ack arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (w_push && !w_flush) begin
            r_mem[r_wptr] <= membus.dat_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_discard  <= '0;
            r_head_adr <= '0;
            r_next_adr <= '0;
            r_valid    <= 1'b0;
            r_ack      <= 1'b0;
            r_dat_s    <= '0;
        end else begin
            r_ack   <= w_hit | w_wr;
            r_dat_s <= w_hit ? r_mem[r_rptr] : '0;
            if (w_flush) begin
                r_valid    <= 1'b1;
                r_head_adr <= cpubus.adr;
                r_next_adr <= cpubus.adr;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_outst    <= '0;
                // Every request still in flight, minus one retiring now, is stale.
                r_discard  <= r_discard + DW'(r_outst) - DW'(membus.ack);
            end else begin
                if (w_hit) begin
                    r_rptr     <= r_rptr + PW'(1);
                    r_head_adr <= r_head_adr + 32'd4;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_fire) begin
                    r_next_adr <= r_next_adr + 32'd4;
                end
                if (w_drop) begin
                    r_discard <= r_discard - DW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_hit);
                r_outst <= r_outst + CW'(w_fire) - CW'(w_push);
            end
        end
    end
endmodule

// File: tb/tb_ins_prefetch.sv
// Directed bench for ins_prefetch: a latency-configurable pipelined memory
// model answers the MMU port while scripted CPU reads/writes are checked.
module tb_ins_prefetch;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   lat;
    logic stale_on;

    if_wb cpu_if();
    if_wb mem_if();

    ins_prefetch #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .cpubus (cpu_if),
        .membus (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F69;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model and bus monitors, evaluated mid-cycle away from both edges.
    logic [31:0] q_adr[$];
    int          q_due[$];
    int          mcyc;
    int          req_cnt;
    int          cyc_seen;
    int          stale_cnt;
    logic [31:0] max_adr;
    logic [31:0] last_adr;

    always @(negedge clk) begin
        #3;
        if (rst) begin
            q_adr.delete();
            q_due.delete();
            mem_if.ack   = 1'b0;
            mem_if.dat_s = '0;
            req_cnt      = 0;
            cyc_seen     = 0;
            stale_cnt    = 0;
            max_adr      = '0;
            last_adr     = '0;
        end else begin
            if (q_due.size() > 0 && q_due[0] == mcyc) begin
                mem_if.ack   = 1'b1;
                mem_if.dat_s = ram_word(q_adr[0]);
                void'(q_adr.pop_front());
                void'(q_due.pop_front());
            end else begin
                mem_if.ack   = 1'b0;
                mem_if.dat_s = '0;
            end
            if (mem_if.cyc && mem_if.stb && !mem_if.stall) begin
                q_adr.push_back(mem_if.adr);
                q_due.push_back(mcyc + lat);
                req_cnt++;
                last_adr = mem_if.adr;
                if (mem_if.adr > max_adr) max_adr = mem_if.adr;
            end
            if (mem_if.cyc) cyc_seen++;
            if (stale_on && cpu_if.ack &&
                (cpu_if.dat_s == ram_word(32'h104) || cpu_if.dat_s == ram_word(32'h108) ||
                 cpu_if.dat_s == ram_word(32'h10C))) stale_cnt++;
        end
        mcyc++;
    end

    task automatic cpu_idle();
        cpu_if.cyc   = 1'b0;
        cpu_if.stb   = 1'b0;
        cpu_if.we    = 1'b0;
        cpu_if.adr   = '0;
        cpu_if.sel   = 4'hF;
        cpu_if.dat_m = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Holds a request until accepted; returns on the negedge where its ack is visible.
    task automatic cpu_issue(input logic w, input logic [31:0] a, output int waits);
        cpu_if.cyc   = 1'b1;
        cpu_if.stb   = 1'b1;
        cpu_if.we    = w;
        cpu_if.adr   = a;
        cpu_if.dat_m = 32'h1234_5678;
        waits = 0;
        #1;
        while (cpu_if.stall && waits < 100) begin
            @(negedge clk);
            #1;
            waits++;
        end
        @(negedge clk);
        cpu_if.cyc = 1'b0;
        cpu_if.stb = 1'b0;
        cpu_if.we  = 1'b0;
    endtask

    task automatic cpu_read_chk(input string tag, input logic [31:0] a, input int exp_waits);
        int waits;
        cpu_issue(1'b0, a, waits);
        $display("read  %s adr=%h waits=%0d ack=%b dat=%h", tag, a, waits, cpu_if.ack, cpu_if.dat_s);
        if (exp_waits >= 0) check_val({tag, "_waits"}, waits, exp_waits);
        check_val({tag, "_ack"}, {31'd0, cpu_if.ack}, 32'd1);
        check_val({tag, "_dat"}, cpu_if.dat_s, ram_word(a));
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        check_val({tag, "_ack"}, {31'd0, cpu_if.ack}, 32'd0);
        check_val({tag, "_dat"}, cpu_if.dat_s, 32'd0);
        check_val({tag, "_mcyc"}, {31'd0, mem_if.cyc}, 32'd0);
        check_val({tag, "_mstb"}, {31'd0, mem_if.stb}, 32'd0);
        check_val({tag, "_madr"}, mem_if.adr, 32'd0);
    endtask

    initial begin
        int waits;
        n_checks = 0;
        n_errors = 0;
        lat = 1;
        stale_on = 1'b0;
        mem_if.stall = 1'b0;
        rst = 1'b1;
        cpu_idle();
        repeat (2) @(negedge clk);

        // Sequential stream, L=1: first ack at cycle 4, then one per cycle.
        lat = 1;
        do_reset();
        check_reset_outputs("rst0");
        cpu_read_chk("seq0", 32'h100, 3);
        for (int i = 1; i < 8; i++) begin
            cpu_read_chk("seq", 32'h100 + 32'(4 * i), 0);
        end
        cpu_idle();
        repeat (10) @(negedge clk);
        check_val("seq_max_adr_ok", {31'd0, max_adr <= 32'h130}, 32'd1);

        // Branch flush, L=5: stale returns must never reach the CPU.
        lat = 5;
        do_reset();
        stale_on = 1'b1;
        cpu_read_chk("br0", 32'h100, 7);
        cpu_read_chk("br_tgt", 32'h400, 7);
        cpu_read_chk("br_tgt1", 32'h404, 0);
        cpu_read_chk("br_tgt2", 32'h408, 0);
        repeat (10) @(negedge clk);
        check_val("br_stale", stale_cnt, 0);
        stale_on = 1'b0;

        // Full buffer: issue stops at DEPTH words ahead; one hit frees one slot.
        lat = 1;
        do_reset();
        cpu_read_chk("full0", 32'h100, 3);
        repeat (15) @(negedge clk);
        #1;
        check_val("full_reqs", req_cnt, 5);
        check_val("full_last", last_adr, 32'h110);
        check_val("full_stb", {31'd0, mem_if.stb}, 32'd0);
        check_val("full_cyc", {31'd0, mem_if.cyc}, 32'd0);
        cpu_read_chk("full1", 32'h104, 0);
        repeat (10) @(negedge clk);
        #1;
        check_val("full_reqs1", req_cnt, 6);
        check_val("full_last1", last_adr, 32'h114);

        // MMU stall: request holds its address and is not counted until released.
        mem_if.stall = 1'b1;
        cpu_read_chk("stl_hit", 32'h108, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("stl_adr", mem_if.adr, 32'h118);
            check_val("stl_stb", {31'd0, mem_if.stb}, 32'd1);
            @(negedge clk);
        end
        #1;
        check_val("stl_reqs", req_cnt, 6);
        mem_if.stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("stl_reqs1", req_cnt, 7);
        check_val("stl_last", last_adr, 32'h118);

        // Address wrap across 2^32 without a flush.
        lat = 1;
        do_reset();
        cpu_read_chk("wrap0", 32'hFFFF_FFF8, 3);
        cpu_read_chk("wrap1", 32'hFFFF_FFFC, 0);
        cpu_read_chk("wrap2", 32'h0000_0000, 0);
        cpu_read_chk("wrap3", 32'h0000_0004, 0);

        // Reset with two requests outstanding.
        lat = 5;
        do_reset();
        cpu_if.cyc = 1'b1;
        cpu_if.stb = 1'b1;
        cpu_if.we  = 1'b0;
        cpu_if.adr = 32'h100;
        repeat (3) @(negedge clk);
        do_reset();
        check_reset_outputs("rst_mid");
        check_val("rst_mid_stall", {31'd0, cpu_if.stall}, 32'd0);
        cpu_read_chk("rst_miss", 32'h100, 7);

        // CPU write: one-cycle ack, zero data, no memory traffic.
        lat = 1;
        do_reset();
        cpu_issue(1'b1, 32'h200, waits);
        $display("write adr=%h waits=%0d ack=%b dat=%h", 32'h200, waits, cpu_if.ack, cpu_if.dat_s);
        check_val("wr_waits", waits, 0);
        check_val("wr_ack", {31'd0, cpu_if.ack}, 32'd1);
        check_val("wr_dat", cpu_if.dat_s, 32'd0);
        @(negedge clk);
        #1;
        check_val("wr_ack_drop", {31'd0, cpu_if.ack}, 32'd0);
        check_val("wr_mem_cyc", cyc_seen, 0);
        check_val("wr_mem_reqs", req_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
